// File: rtl/bcd_timer_core.sv
// bcd_timer_core: two-digit BCD up/down timer with start/stop/clear/load control.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start/stop/clr/load one-cycle control requests (priority clr > load > stop > start)
//   dir               0 = count up, 1 = count down, sampled on each tick
//   pre1/pre2         preset tens/ones digits (BCD, clamped to 9 on load)
//   num1/num2         registered tens/ones display digits
//   running           high while in RUN
//   tick_out          one-cycle pulse after each count step
//   done              one-cycle pulse on up-wrap or down-expiry
//   alarm             (only with TIMER_ALARM_EN) ALARM_LEN-cycle pulse on entering DONE
// Optional feature macro: TIMER_ALARM_EN
module bcd_timer_core #(
    parameter int TICK_DIV  = 100000000,
    parameter int WRAP      = 60,
    parameter int ALARM_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clr,
    input  logic       load,
    input  logic       dir,
    input  logic [3:0] pre1,
    input  logic [3:0] pre2,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic       running,
    output logic       tick_out,
    output logic       done
`ifdef TIMER_ALARM_EN
    ,
    output logic       alarm
`endif
);
    localparam int DW = $clog2(TICK_DIV);
    localparam logic [3:0] MAX1 = 4'((WRAP - 1) / 10);
    localparam logic [3:0] MAX2 = 4'((WRAP - 1) % 10);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state, state_n;
    logic [DW-1:0] div, div_n;
    logic [3:0]    n1_n, n2_n, l1, l2;
    logic [6:0]    lval;
    logic          tick_n, done_n, ld_ok;

    assign ld_ok = load && state != RUN;
    assign l1    = (pre1 > 4'd9) ? 4'd9 : pre1;
    assign l2    = (pre2 > 4'd9) ? 4'd9 : pre2;
    assign lval  = 7'(l1) * 7'd10 + 7'(l2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div      <= '0;
            num1     <= '0;
            num2     <= '0;
            running  <= 1'b0;
            tick_out <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            div      <= div_n;
            num1     <= n1_n;
            num2     <= n2_n;
            running  <= state_n == RUN;
            tick_out <= tick_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        div_n   = div;
        n1_n    = num1;
        n2_n    = num2;
        tick_n  = 1'b0;
        done_n  = 1'b0;
        if (clr) begin
            state_n = IDLE;
            div_n   = '0;
            n1_n    = '0;
            n2_n    = '0;
        end else if (ld_ok) begin
            state_n = IDLE;
            div_n   = '0;
            {n1_n, n2_n} = (lval >= 7'(WRAP)) ? {MAX1, MAX2} : {l1, l2};
        end else if (stop && state == RUN) begin
            state_n = PAUSE;
        end else if (start && state == IDLE) begin
            div_n = '0;
            // Starting a down-count from 00 expires immediately.
            if (dir && num1 == 4'd0 && num2 == 4'd0) begin
                state_n = DONE;
                done_n  = 1'b1;
            end else begin
                state_n = RUN;
            end
        end else if (start && state == PAUSE) begin
            state_n = RUN;
        end else if (state == RUN) begin
            if (div == DW'(TICK_DIV - 1)) begin
                div_n  = '0;
                tick_n = 1'b1;
                if (!dir) begin
                    if (num1 == MAX1 && num2 == MAX2) begin
                        n1_n   = '0;
                        n2_n   = '0;
                        done_n = 1'b1;
                    end else if (num2 == 4'd9) begin
                        n2_n = '0;
                        n1_n = num1 + 4'd1;
                    end else begin
                        n2_n = num2 + 4'd1;
                    end
                end else begin
                    // Down from 00 (reachable after an up-wrap) rolls to WRAP-1.
                    if (num1 == 4'd0 && num2 == 4'd0) begin
                        n1_n = MAX1;
                        n2_n = MAX2;
                    end else if (num2 == 4'd0) begin
                        n2_n = 4'd9;
                        n1_n = num1 - 4'd1;
                    end else begin
                        n2_n = num2 - 4'd1;
                        if (num1 == 4'd0 && num2 == 4'd1) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end
                    end
                end
            end else begin
                div_n = div + DW'(1);
            end
        end
    end

`ifdef TIMER_ALARM_EN
    localparam int AW = $clog2(ALARM_LEN + 1);

    logic [AW-1:0] acnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm <= 1'b0;
            acnt  <= '0;
        end else if (clr || ld_ok) begin
            alarm <= 1'b0;
            acnt  <= '0;
        end else if (state_n == DONE && state != DONE) begin
            alarm <= 1'b1;
            acnt  <= AW'(ALARM_LEN - 1);
        end else if (alarm) begin
            if (acnt == '0) alarm <= 1'b0;
            else acnt <= acnt - AW'(1);
        end
    end
`endif
endmodule

// File: tb/tb_bcd_timer_core.sv
// tb_bcd_timer_core: randomized and directed checks of bcd_timer_core against an integer reference model.
module tb_bcd_timer_core;
    localparam int TD = 4;
    localparam int WR = 60;
    localparam int AL = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, clr = 1'b0, load = 1'b0, dir = 1'b0;
    logic [3:0] pre1 = 4'd0, pre2 = 4'd0;
    logic [3:0] num1, num2;
    logic       running, tick_out, done;
`ifdef TIMER_ALARM_EN
    logic       alarm;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: count as a plain integer, phase within the current tick,
    // state as 0 idle / 1 run / 2 pause / 3 done.
    int m_val, m_st, m_ph, m_alarm_left;
    logic e_tick, e_done;

    bcd_timer_core #(.TICK_DIV(TD), .WRAP(WR), .ALARM_LEN(AL)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .load(load),
        .dir(dir), .pre1(pre1), .pre2(pre2), .num1(num1), .num2(num2),
        .running(running), .tick_out(tick_out), .done(done)
`ifdef TIMER_ALARM_EN
        , .alarm(alarm)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_val = 0; m_st = 0; m_ph = 0; m_alarm_left = 0; e_tick = 0; e_done = 0;
    endtask

    task automatic model_edge();
        int a, b;
        bit enter;
        enter = 0; e_tick = 0; e_done = 0;
        if (clr) begin
            m_val = 0; m_st = 0; m_ph = 0;
        end else if (load && m_st != 1) begin
            a = (pre1 > 9) ? 9 : int'(pre1);
            b = (pre2 > 9) ? 9 : int'(pre2);
            m_val = (a * 10 + b >= WR) ? WR - 1 : a * 10 + b;
            m_st = 0; m_ph = 0;
        end else if (stop && m_st == 1) begin
            m_st = 2;
        end else if (start && m_st == 0) begin
            m_ph = 0;
            if (dir && m_val == 0) begin m_st = 3; e_done = 1; enter = 1; end
            else m_st = 1;
        end else if (start && m_st == 2) begin
            m_st = 1;
        end else if (m_st == 1) begin
            m_ph++;
            if (m_ph == TD) begin
                m_ph = 0; e_tick = 1;
                if (!dir) begin
                    m_val = (m_val + 1) % WR;
                    if (m_val == 0) e_done = 1;
                end else begin
                    m_val = (m_val + WR - 1) % WR;
                    if (m_val == 0) begin m_st = 3; e_done = 1; enter = 1; end
                end
            end
        end
        if (clr || (load && m_st == 0 && !enter)) m_alarm_left = 0;
        else if (enter) m_alarm_left = AL;
        else if (m_alarm_left > 0) m_alarm_left--;
    endtask

    function automatic logic [10:0] exp_vec();
        return {4'(m_val / 10), 4'(m_val % 10), m_st == 1, e_tick, e_done};
    endfunction

    // One clock edge: the model sees the same inputs the DUT samples, then pulses are released.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        start = 0; stop = 0; clr = 0; load = 0;
    endtask

    task automatic test_reset();
        rst = 1; model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({num1, num2, running, tick_out, done} !== 11'd0) begin
            errors++; $display("FAIL reset_state: got %h want 000", {num1, num2, running, tick_out, done});
        end
        rst = 0;
        start = 1; cyc();
        repeat (6) cyc();
        #2 rst = 1;
        #1;
        checks++;
        if ({num1, num2, running, tick_out, done} !== 11'd0) begin
            errors++; $display("FAIL async_reset: got %h want 000", {num1, num2, running, tick_out, done});
        end
`ifdef TIMER_ALARM_EN
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %b want 0", alarm); end
`endif
        model_reset();
        @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_count_up();
        int n;
        n = 0;
        dir = 0; start = 1; cyc();
        for (int i = 1; i <= 8 && n == 0; i++) begin
            cyc();
            checks++;
            if ({num1, num2, running, tick_out, done} !== exp_vec()) begin
                errors++; $display("FAIL up_cycle: got %h want %h", {num1, num2, running, tick_out, done}, exp_vec());
            end
            if (tick_out) n = i;
        end
        checks++;
        if (n != TD) begin errors++; $display("FAIL first_tick_latency: got %0d want %0d", n, TD); end
        checks++;
        if ({num1, num2} !== 8'h01) begin errors++; $display("FAIL first_count: got %h want 01", {num1, num2}); end
        repeat (9 * TD) cyc();
        checks++;
        if ({num1, num2} !== 8'h10) begin errors++; $display("FAIL ten_ticks: got %h want 10", {num1, num2}); end
    endtask

    task automatic test_wrap_up();
        int dones;
        dones = 0;
        clr = 1; cyc();
        pre1 = 5; pre2 = 8; load = 1; cyc();
        checks++;
        if ({num1, num2} !== 8'h58) begin errors++; $display("FAIL load_58: got %h want 58", {num1, num2}); end
        dir = 0; start = 1; cyc();
        for (int i = 0; i < 2 * TD; i++) begin
            cyc();
            dones += int'(done);
            checks++;
            if ({num1, num2, running, tick_out, done} !== exp_vec()) begin
                errors++; $display("FAIL wrap_cycle: got %h want %h", {num1, num2, running, tick_out, done}, exp_vec());
            end
        end
        checks++;
        if (dones != 1 || {num1, num2} !== 8'h00 || running !== 1'b1) begin
            errors++; $display("FAIL up_wrap: got dones=%0d num=%h run=%b want 1 00 1", dones, {num1, num2}, running);
        end
    endtask

    task automatic test_count_down();
        int dones;
        dones = 0;
        clr = 1; cyc();
        pre1 = 0; pre2 = 3; load = 1; cyc();
        dir = 1; start = 1; cyc();
        for (int i = 0; i < 3 * TD; i++) begin
            cyc();
            dones += int'(done);
            checks++;
            if ({num1, num2, running, tick_out, done} !== exp_vec()) begin
                errors++; $display("FAIL down_cycle: got %h want %h", {num1, num2, running, tick_out, done}, exp_vec());
            end
        end
        checks++;
        if (dones != 1 || {num1, num2} !== 8'h00 || running !== 1'b0) begin
            errors++; $display("FAIL down_expire: got dones=%0d num=%h run=%b want 1 00 0", dones, {num1, num2}, running);
        end
        start = 1; cyc();
        repeat (2 * TD) cyc();
        checks++;
        if ({num1, num2, running, tick_out, done} !== 11'd0) begin
            errors++; $display("FAIL done_hold: got %h want 000", {num1, num2, running, tick_out, done});
        end
    endtask

    task automatic test_pause();
        logic [7:0] held;
        int n;
        n = 0;
        clr = 1; cyc();
        dir = 0; start = 1; cyc();
        repeat (2) cyc();
        stop = 1; cyc();
        held = {num1, num2};
        repeat (10) cyc();
        checks++;
        if ({num1, num2, running, tick_out} !== {held, 2'b00}) begin
            errors++; $display("FAIL pause_hold: got %h want %h00", {num1, num2, running, tick_out}, held);
        end
        start = 1; cyc();
        for (int i = 1; i <= 6 && n == 0; i++) begin
            cyc();
            if (tick_out) n = i;
        end
        checks++;
        if (n != 2 || {num1, num2} !== 8'h01) begin
            errors++; $display("FAIL resume_tick: got %0d cycles num=%h want 2 01", n, {num1, num2});
        end
    endtask

    task automatic test_load_clamp();
        clr = 1; cyc();
        pre1 = 7; pre2 = 12; load = 1; cyc();
        checks++;
        if ({num1, num2} !== 8'h59) begin errors++; $display("FAIL load_clamp: got %h want 59", {num1, num2}); end
        dir = 0; start = 1; cyc();
        repeat (2) cyc();
        pre1 = 1; pre2 = 1; load = 1; cyc();
        checks++;
        if ({num1, num2, running} !== 9'h0B3) begin
            errors++; $display("FAIL load_in_run: got %h want 0b3", {num1, num2, running});
        end
        clr = 1; start = 1; cyc();
        checks++;
        if ({num1, num2, running} !== 9'h000) begin
            errors++; $display("FAIL clr_start: got %h want 000", {num1, num2, running});
        end
    endtask

`ifdef TIMER_ALARM_EN
    task automatic test_alarm();
        int highs, seen;
        highs = 0; seen = 0;
        clr = 1; cyc();
        pre1 = 0; pre2 = 2; load = 1; cyc();
        dir = 1; start = 1; cyc();
        for (int i = 0; i < 40; i++) begin
            cyc();
            highs += int'(alarm);
        end
        checks++;
        if (highs != AL) begin errors++; $display("FAIL alarm_len: got %0d want %0d", highs, AL); end
        clr = 1; cyc();
        pre1 = 0; pre2 = 1; load = 1; cyc();
        start = 1; cyc();
        for (int i = 0; i < 10 && !seen; i++) begin cyc(); seen = int'(alarm); end
        repeat (4) cyc();
        checks++;
        if (alarm !== 1'b1) begin errors++; $display("FAIL alarm_held: got %b want 1", alarm); end
        clr = 1; cyc();
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL alarm_clr: got %b want 0", alarm); end
    endtask
`endif

    task automatic test_random();
        int r;
        clr = 1; cyc();
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            start = r < 10;
            stop  = r >= 10 && r < 13;
            clr   = r == 13;
            load  = r >= 14 && r < 17;
            pre1  = 4'($urandom_range(0, 15));
            pre2  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) dir = ~dir;
            cyc();
            checks++;
            if ({num1, num2, running, tick_out, done} !== exp_vec()) begin
                errors++; $display("FAIL rand_cycle %0d: got %h want %h", i, {num1, num2, running, tick_out, done}, exp_vec());
            end
`ifdef TIMER_ALARM_EN
            checks++;
            if (alarm !== (m_alarm_left > 0)) begin
                errors++; $display("FAIL rand_alarm %0d: got %b want %b", i, alarm, m_alarm_left > 0);
            end
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_count_up();
        test_wrap_up();
        test_count_down();
        test_pause();
        test_load_clamp();
`ifdef TIMER_ALARM_EN
        test_alarm();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_timer_core.md
Name: bcd_timer_core

Overview:
- Two-digit BCD timer counter that produces the live display digits num1 (tens) and num2 (ones).
- Sits directly upstream of the timer display mux. Its num1/num2 feed the mux "num" inputs. The mux save1/save2 outputs return here as preset inputs pre1/pre2.
- Supports start/stop/clear/load control and counting up or down. A clock-divided tick advances the count.

Parameters:
- TICK_DIV, 100000000: clk cycles per count step; must be >= 2.
- WRAP, 60: count range is 00..WRAP-1; legal range 2..100.
- ALARM_LEN, 16: alarm pulse length in clk cycles; used only with TIMER_ALARM_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: asynchronous, active-high
- start  in  1  one-cycle request to run or resume
- stop  in  1  one-cycle request to pause
- clr  in  1  one-cycle request to zero the count and go IDLE
- load  in  1  one-cycle request to load pre1/pre2
- dir  in  1  0 = count up, 1 = count down; sampled on each tick
- pre1  in  4  preset tens digit (BCD)
- pre2  in  4  preset ones digit (BCD)
- num1  out  4  tens digit, registered
- num2  out  4  ones digit, registered
- running  out  1  high while in RUN
- tick_out  out  1  one-cycle pulse on each count step
- done  out  1  one-cycle pulse on up-wrap or down-expiry

Behaviour:
- Reset (async, rst=1): num1=0, num2=0, state=IDLE, divider=0; running, tick_out, done all 0.
- States are IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Control priority within one cycle: clr > load > stop > start.
- clr, any state: next cycle num=00, state IDLE, divider 0.
- load:
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - Each digit above 9 is clamped to 9.
  - If the resulting value is >= WRAP, the count becomes WRAP-1 in BCD.
  - After a load, state is IDLE and divider is 0.
- start:
  - From IDLE: go to RUN with divider 0.
  - From PAUSE: go to RUN with the divider kept, so the partial tick resumes.
  - Ignored in DONE and RUN.
  - From IDLE with dir=1 and count 00: go to DONE instead, with a done pulse on the same edge.
- stop: RUN -> PAUSE; the divider is held. Ignored in every other state.
- Divider and tick:
  - In RUN the divider counts 0..TICK_DIV-1.
  - At TICK_DIV-1 it returns to 0 and a tick occurs. tick_out is high in the cycle after that edge.
  - The count updates on the same edge as the tick, so latency from start to the first count change is TICK_DIV cycles.
- Count up (dir=0) on a tick:
  - Ones 9 -> 0 with carry into tens.
  - Value WRAP-1 -> 00, done pulses, state stays RUN.
- Count down (dir=1) on a tick:
  - Ones 0 -> 9 with borrow from tens.
  - When the new value is 00: state goes to DONE, running drops, done pulses.
- DONE holds the count. Only clr or load leave it.
- A dir change takes effect at the next tick; there is no glitch on the digits.
- Any clr/load/stop arriving in the same cycle as a tick takes priority over the tick. The tick is discarded.
- num1/num2 are always valid BCD 0..9 and always < WRAP.
- rst asserted mid-count: immediate return to reset values with no pending pulses.

Optional Feature:
- Macro: TIMER_ALARM_EN.
- Defined:
  - Adds output port alarm (out, 1).
  - alarm rises on the edge that enters DONE and stays high for ALARM_LEN cycles.
  - clr, load or rst clears it early.
  - An up-wrap does not raise alarm.
- Undefined: no alarm port, no alarm counter logic. Every other behaviour is identical.

Test Plan (bench uses TICK_DIV=4, WRAP=60):
- Reset then start, dir=0 -> first tick_out after 4 cycles; num 00->01; after 10 ticks num1=1, num2=0.
- Load pre=5,8, dir=0, start -> 58, 59, then 00 with a done pulse; state stays RUN, running=1.
- Load pre=0,3, dir=1, start -> 02, 01, 00; done pulses once; running=0; further start ignored; count holds at 00.
- Run 2 cycles into a tick, stop, wait 10 cycles, start -> next tick 2 cycles after resume; count unchanged during PAUSE.
- load with pre=7,12 -> count 59; load during RUN ignored; clr and start in the same cycle -> 00 and IDLE.
- With TIMER_ALARM_EN: down-count to 00 -> alarm high for exactly 16 cycles; a clr on cycle 5 drops alarm next cycle.
